// File: rtl/lsr_pkg.sv
// Shared types and helpers for the CNN layer sequencer / router.
// Holds the FSM state encoding, layer-index width and the LeNet buffer maps.
package lsr_pkg;

    localparam int LIDX_W = 4;

    localparam logic [14:0] LENET_SRC_MAP = 15'h4688;
    localparam logic [14:0] LENET_DST_MAP = 15'h38D1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_FIN,
        S_ERR
    } lsr_state_e;

    // Returns field idx (w bits wide) of a packed per-layer map.
    function automatic int map_field(input logic [63:0] map, input int idx, input int w);
        logic [63:0] sh;
        sh = (map >> (idx * w)) & ((64'd1 << w) - 64'd1);
        return int'(sh);
    endfunction

endpackage

// File: rtl/lsr_onehot_mux.sv
// N-way AND-OR bus selector; an all-zero select yields an all-zero output.
module lsr_onehot_mux #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic [N-1:0]   sel_i,
    input  logic [N*W-1:0] data_i,
    output logic [W-1:0]   data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < N; i++) begin
            data_o = data_o | (data_i[i*W +: W] & {W{sel_i[i]}});
        end
    end

endmodule

// File: rtl/layer_seq_router.sv
// Table-driven layer sequencer and datapath router for the systolic CNN core.
// Optional per-layer cycle counter is built when LSR_PERF_CNT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | input RAM load pulse (mem_init), one cycle
// RUN     | layer k active, waiting for layer_done
// DRAIN   | holding layer k for DRAIN_CYC cycles
// FIN     | done pulse, one cycle
// ERR     | watchdog expired, waiting for start
module layer_seq_router
    import lsr_pkg::*;
#(
    parameter int DW         = 16,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int NUM_LAYERS = 5,
    parameter int NUM_BUFS   = 4,
    parameter int BSEL_W     = 3,
    parameter logic [NUM_LAYERS*BSEL_W-1:0] SRC_MAP = LENET_SRC_MAP,
    parameter logic [NUM_LAYERS*BSEL_W-1:0] DST_MAP = LENET_DST_MAP,
    parameter int DRAIN_CYC  = 4,
    parameter logic [19:0] TIMEOUT = 20'd0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [LIDX_W-1:0]                layer_index,
    output logic                             mem_init,
    output logic                             layer_start,
    input  logic                             layer_done,
    input  logic                             ra_en,
    input  logic                             wr_en,
    input  logic [(NUM_BUFS+1)*ROWS*DW-1:0]  src_data_i,
    input  logic [NUM_LAYERS*COLS*DW-1:0]    w_data_i,
    input  logic [NUM_LAYERS*COLS*DW-1:0]    b_data_i,
    output logic [ROWS*DW-1:0]               din_inf,
    output logic [COLS*DW-1:0]               din_weight,
    output logic [COLS*DW-1:0]               din_bias,
    output logic [NUM_BUFS:0]                buf_rd_en,
    output logic [NUM_BUFS-1:0]              buf_wr_en,
    output logic [NUM_LAYERS-1:0]            layer_en,
    output logic [NUM_LAYERS-1:0]            rom_rd_en
`ifdef LSR_PERF_CNT_EN
    ,
    output logic [31:0]                      layer_cycles,
    output logic                             layer_cycles_vld
`endif
);

    localparam logic [LIDX_W-1:0] LAST_K     = LIDX_W'(NUM_LAYERS - 1);
    localparam logic [15:0]       DRAIN_LOAD = (DRAIN_CYC > 0) ? 16'(DRAIN_CYC - 1) : 16'd0;
    localparam logic [19:0]       WD_LOAD    = TIMEOUT - 20'd1;

    lsr_state_e        state_q, state_d;
    logic [LIDX_W-1:0] k_q, k_d;
    logic [15:0]       drain_q, drain_d;
    logic [19:0]       wd_q, wd_d;
    logic              ls_q, ls_d;
    logic              layer_exit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            drain_q <= '0;
            wd_q    <= '0;
            ls_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            wd_q    <= wd_d;
            ls_q    <= ls_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        drain_d    = drain_q;
        wd_d       = wd_q;
        ls_d       = 1'b0;
        layer_exit = 1'b0;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_RUN;
                k_d     = '0;
                ls_d    = 1'b1;
                wd_d    = WD_LOAD;
            end
            S_RUN: begin
                // layer_done takes priority over a coincident watchdog expiry
                if (layer_done) begin
                    if (DRAIN_CYC == 0) begin
                        layer_exit = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end else if (TIMEOUT != 20'd0 && wd_q == 20'd0) begin
                    state_d = S_ERR;
                end else begin
                    wd_d = wd_q - 20'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q == 16'd0) layer_exit = 1'b1;
                else                  drain_d = drain_q - 16'd1;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (layer_exit) begin
            if (k_q == LAST_K) begin
                state_d = S_FIN;
            end else begin
                state_d = S_RUN;
                k_d     = k_q + 1'b1;
                ls_d    = 1'b1;
                wd_d    = WD_LOAD;
            end
        end
    end

    logic                  active;
    int                    src_idx, dst_idx;
    logic [NUM_BUFS:0]     src_oh;
    logic [NUM_BUFS-1:0]   dst_oh;
    logic [NUM_LAYERS-1:0] layer_oh;

    assign active = (state_q == S_RUN) || (state_q == S_DRAIN);

    // Out-of-range map fields fall back to input RAM / no write.
    always_comb begin
        src_idx = map_field(64'(SRC_MAP), int'(k_q), BSEL_W);
        dst_idx = map_field(64'(DST_MAP), int'(k_q), BSEL_W);
        if (src_idx > NUM_BUFS) src_idx = 0;
        if (dst_idx > NUM_BUFS) dst_idx = 0;
        for (int i = 0; i <= NUM_BUFS; i++) src_oh[i] = active && (src_idx == i);
        for (int i = 0; i < NUM_BUFS; i++)  dst_oh[i] = active && (dst_idx == i + 1);
        for (int i = 0; i < NUM_LAYERS; i++) layer_oh[i] = active && (int'(k_q) == i);
    end

    assign busy        = (state_q == S_LOAD) || active;
    assign done        = (state_q == S_FIN);
    assign err         = (state_q == S_ERR);
    assign mem_init    = (state_q == S_LOAD);
    assign layer_start = ls_q;
    assign layer_index = active ? k_q + 1'b1 : '0;
    assign buf_rd_en   = src_oh & {(NUM_BUFS+1){ra_en}};
    assign buf_wr_en   = dst_oh & {NUM_BUFS{wr_en}};
    assign layer_en    = layer_oh;
    assign rom_rd_en   = layer_oh & {NUM_LAYERS{ra_en}};

    lsr_onehot_mux #(.N(NUM_BUFS+1), .W(ROWS*DW)) u_mux_inf (
        .sel_i (src_oh),
        .data_i(src_data_i),
        .data_o(din_inf)
    );

    lsr_onehot_mux #(.N(NUM_LAYERS), .W(COLS*DW)) u_mux_weight (
        .sel_i (layer_oh),
        .data_i(w_data_i),
        .data_o(din_weight)
    );

    lsr_onehot_mux #(.N(NUM_LAYERS), .W(COLS*DW)) u_mux_bias (
        .sel_i (layer_oh),
        .data_i(b_data_i),
        .data_o(din_bias)
    );

`ifdef LSR_PERF_CNT_EN
    logic [31:0] pc_q, pc_lat_q;
    logic        pc_vld_q;

    // Count includes both the layer_start cycle and the layer_done cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= '0;
            pc_lat_q <= '0;
            pc_vld_q <= 1'b0;
        end else begin
            pc_vld_q <= 1'b0;
            if (ls_d)                    pc_q <= '0;
            else if (state_q == S_RUN)   pc_q <= pc_q + 32'd1;
            if (state_q == S_RUN && layer_done) begin
                pc_lat_q <= pc_q + 32'd1;
                pc_vld_q <= 1'b1;
            end
        end
    end

    assign layer_cycles     = pc_lat_q;
    assign layer_cycles_vld = pc_vld_q;
`endif

endmodule
